axi_rr_arb: RTL and testbench

- N-to-1 round-robin arbiter sharing one valid/ready data channel between N requesters.
- The output side is a registered forward stage: s_data, s_valid and s_id are flops, with zero bubble at full throughput.
- Sits in front of AXI channel sinks (W/AR/AW mux points) wherever several masters feed one downstream slice.

---
 rtl/axi_rr_arb_pkg.sv | 19 +
 rtl/axi_rr_pick.sv | 28 ++
 rtl/axi_rr_arb.sv | 113 +++++++++++
 tb/tb_axi_rr_arb.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and a
// ceiling-log2 helper used to validate the id width against the requester count.
package axi_rr_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or after ptr,
// wrapping from N-1 back to 0.
module axi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt,
  output logic          any
);

  always_comb begin
    int idx;
    gnt = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any = 1'b1;
        gnt = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_rr_arb.sv
// N-to-1 round-robin arbiter with a registered forward output stage.
// Define AXI_RR_ARB_LAST_EN to add m_last/s_last and hold the grant across a packet.
//
// state | meaning
// ARB   | grant free; rotating pick from ptr each cycle
// HOLD  | grant locked to gnt_q until that requester transfers (its last beat)
module axi_rr_arb
  import axi_rr_arb_pkg::*;
#(
  parameter int DW = 64,
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N*DW-1:0] m_data,
  input  logic [N-1:0]  m_valid,
  output logic [N-1:0]  m_ready,
`ifdef AXI_RR_ARB_LAST_EN
  input  logic [N-1:0]  m_last,
  output logic          s_last,
`endif
  output logic [DW-1:0] s_data,
  output logic          s_valid,
  output logic [IW-1:0] s_id,
  input  logic          s_ready
);

  if (clog2(N) > IW) begin : g_iw_check
    $error("axi_rr_arb: IW too small for N");
  end

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] gnt;
  logic [IW-1:0] g;
  logic [IW-1:0] ptr_inc;
  logic [DW-1:0] g_data;
  logic [N-1:0]  last_sh;
  logic          any;
  logic          acc;
  logic          xfer;
  logic          last_g;

  axi_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (m_valid),
    .ptr (ptr),
    .gnt (gnt),
    .any (any)
  );

  always_comb begin
    acc     = ~s_valid | s_ready;
    g       = (state == HOLD) ? gnt_q : gnt;
    m_ready = '0;
    // m_ready is gated by rst_n so it drops the instant reset asserts
    if (rst_n) begin
      if (state == HOLD) m_ready = {{(N-1){1'b0}}, acc} << gnt_q;
      else if (any && acc) m_ready = {{(N-1){1'b0}}, 1'b1} << gnt;
    end
    xfer    = |(m_valid & m_ready);
    ptr_inc = (g == IW'(N-1)) ? '0 : g + 1'b1;
    g_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (g == IW'(i)) g_data = m_data[i*DW +: DW];
    end
`ifdef AXI_RR_ARB_LAST_EN
    last_sh = m_last >> g;
`else
    last_sh = '1;
`endif
    last_g  = last_sh[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB;
      ptr     <= '0;
      gnt_q   <= '0;
      s_data  <= '0;
      s_valid <= 1'b0;
      s_id    <= '0;
`ifdef AXI_RR_ARB_LAST_EN
      s_last  <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        s_data  <= g_data;
        s_id    <= g;
        s_valid <= 1'b1;
`ifdef AXI_RR_ARB_LAST_EN
        s_last  <= last_g;
`endif
        if (last_g) begin
          state <= ARB;
          ptr   <= ptr_inc;
        end else begin
          // mid-packet: keep the grant and leave ptr where it is
          state <= HOLD;
          gnt_q <= g;
        end
      end else begin
        if (s_ready) s_valid <= 1'b0;
        if (state == ARB && any && !acc) begin
          state <= HOLD;
          gnt_q <= gnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_rr_arb.sv
// Randomized and directed bench for axi_rr_arb against a cycle-level reference model.
module tb_axi_rr_arb;
  localparam int DW = 64;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_ready;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic [IW-1:0]   s_id;
  logic            s_ready;
`ifdef AXI_RR_ARB_LAST_EN
  logic [N-1:0]    m_last;
  logic            s_last;
`endif

  axi_rr_arb #(.DW(DW), .N(N), .IW(IW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
`ifdef AXI_RR_ARB_LAST_EN
    .m_last  (m_last),
    .s_last  (s_last),
`endif
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_id    (s_id),
    .s_ready (s_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // reference model: what the output register should hold, and the grant lock
  bit            e_valid;
  logic [DW-1:0] e_data;
  int            e_id;
  bit            e_last;
  int            mptr;
  bit            mhold;
  int            mhid;

  task automatic model_reset();
    e_valid = 0; e_data = '0; e_id = 0; e_last = 0;
    mptr = 0; mhold = 0; mhid = 0;
  endtask

  // inputs are applied at the falling edge before calling
  task automatic step();
    int g;
    bit acc;
    bit last;
    logic [N-1:0] e_ready;
    #1;
    acc = !e_valid || s_ready;
    e_ready = '0;
    g = -1;
    if (!mhold) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (mptr + k) % N;
        if (g < 0 && m_valid[i]) g = i;
      end
      if (g >= 0) begin
        if (acc) e_ready[g] = 1'b1;
        else begin
          mhold = 1; mhid = g; g = -1;
        end
      end
    end else begin
      if (acc) begin
        e_ready[mhid] = 1'b1;
        if (m_valid[mhid]) g = mhid;
      end
    end
    chk("m_ready", m_ready, e_ready);
    chk("m_ready_onehot0", 64'($onehot0(m_ready)), 64'd1);
    if (g >= 0) begin
      e_data  = m_data[g*DW +: DW];
      e_id    = g;
      e_valid = 1;
`ifdef AXI_RR_ARB_LAST_EN
      last = m_last[g];
`else
      last = 1;
`endif
      e_last = last;
      if (last) begin
        mhold = 0; mptr = (g + 1) % N;
      end else begin
        mhold = 1; mhid = g;
      end
    end else if (s_ready) begin
      e_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("s_valid", s_valid, e_valid);
    chk("s_data", s_data, e_data);
    chk("s_id", s_id, e_id);
`ifdef AXI_RR_ARB_LAST_EN
    chk("s_last", s_last, e_last);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_valid = '1;
    s_ready = 1'b0;
    for (int i = 0; i < N; i++) m_data[i*DW +: DW] = 64'h100 + 64'(i);
`ifdef AXI_RR_ARB_LAST_EN
    m_last = '1;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_s_id", s_id, 0);
    chk("rst_m_ready", m_ready, 0);
    rst_n = 1'b1;

    // round-robin order with wrap
    s_ready = 1'b1;
    m_valid = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", s_id, k % N);
      chk("rr_valid", s_valid, 1);
    end

    // sparse request, then verify ptr moved to 3
    m_valid = 4'b0100;
    m_data[2*DW +: DW] = 64'hA5;
    step();
    chk("sparse_data", s_data, 64'hA5);
    chk("sparse_id", s_id, 2);
    m_valid = '1;
    step();
    chk("sparse_ptr", s_id, 3);

    // stall lock: requester 1 latched, 0 arrives while stalled
    s_ready = 1'b0;
    m_valid = 4'b0010;
    step();
    chk("stall_ready0", m_ready, 0);
    m_valid = 4'b0011;
    step();
    s_ready = 1'b1;
    step();
    chk("stall_first", s_id, 1);
    step();
    chk("stall_second", s_id, 0);

    // drain
    m_valid = 4'b0100;
    m_data[2*DW +: DW] = 64'h5A5A;
    step();
    m_valid = '0;
    step();
    chk("drain_valid", s_valid, 0);
    chk("drain_hold", s_data, 64'h5A5A);

    // async reset between edges
    m_valid = '1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_s_valid", s_valid, 0);
    chk("async_m_ready", m_ready, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m_valid = 4'b0110;
    step();
    chk("post_rst_gnt", s_id, 1);

`ifdef AXI_RR_ARB_LAST_EN
    do_reset();
    s_ready = 1'b1;
    m_last  = '1;
    m_valid = 4'b0100;
    step();
    m_valid = 4'b1001;
    m_last  = 4'b0000;
    step();
    chk("pkt_b0_id", s_id, 3);
    chk("pkt_b0_last", s_last, 0);
    step();
    chk("pkt_b1_id", s_id, 3);
    chk("pkt_b1_last", s_last, 0);
    m_last = 4'b1000;
    step();
    chk("pkt_b2_id", s_id, 3);
    chk("pkt_b2_last", s_last, 1);
    m_last = '1;
    step();
    chk("pkt_next_id", s_id, 0);
`endif

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      m_valid = N'($urandom);
      for (int i = 0; i < N; i++) m_data[i*DW +: DW] = {$urandom, $urandom};
      s_ready = ($urandom % 4) != 0;
`ifdef AXI_RR_ARB_LAST_EN
      m_last = N'($urandom);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
